// File: rtl/mem_min_scanner.sv
// mem_min_scanner
//
// Bus initiator that walks a signed 32-bit word array in the shared data
// memory, tracks the running signed minimum and writes that minimum back to
// a destination word. The datapath and this block share the memory through
// an external mux selected by busy.
//
// Ports:
//   clk       rising-edge clock shared with the data memory
//   rst       asynchronous active-high reset
//   start     scan request, sampled only while idle
//   base_adr  byte address of element 0 (word-aligned)
//   count     number of elements to scan
//   dst_adr   byte address that receives the minimum (word-aligned)
//   adr       memory byte address
//   wdata     memory write data (to the memory d_in)
//   mrd       memory read enable
//   mwr       memory write enable
//   rdata     memory read data (from the memory d_out, combinational)
//   busy      high while a scan occupies the memory port
//   done      one-cycle completion pulse
//   min_val   signed minimum of the last completed scan
module mem_min_scanner #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_adr,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      dst_adr,
    output logic [31:0]      adr,
    output logic [31:0]      wdata,
    output logic             mrd,
    output logic             mwr,
    input  logic [31:0]      rdata,
    output logic             busy,
    output logic             done,
    output logic [31:0]      min_val
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      base_r;
    logic [31:0]      dst_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] idx;
    logic [31:0]      min_r;
    logic             last_read;

    // cnt_r is never zero in READ, so the decrement cannot underflow. Comparing
    // against count-1 instead of count keeps a count of 2^CNT_W-1 in range.
    assign last_read = (idx == (cnt_r - CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus outputs are decoded from the state and latched registers only, so
    // neither start nor rdata can reach adr/wdata/mrd/mwr combinationally.
    always_comb begin
        state_next = state;
        adr        = 32'd0;
        wdata      = 32'd0;
        mrd        = 1'b0;
        mwr        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy = 1'b1;
                mrd  = 1'b1;
                adr  = base_r + (32'(idx) << 2);
                if (last_read) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy  = 1'b1;
                mwr   = 1'b1;
                adr   = dst_r;
                wdata = min_r;
                state_next = DONE;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands are captured once at acceptance so later input changes cannot
    // disturb a scan in flight. Equal elements keep the current minimum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r  <= 32'd0;
            dst_r   <= 32'd0;
            cnt_r   <= '0;
            idx     <= '0;
            min_r   <= 32'd0;
            min_val <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r <= base_adr;
                        dst_r  <= dst_adr;
                        cnt_r  <= count;
                        idx    <= '0;
                        min_r  <= 32'h7FFF_FFFF;
                        if (count == '0) begin
                            min_val <= 32'h7FFF_FFFF;
                        end
                    end
                end
                READ: begin
                    if ($signed(rdata) < $signed(min_r)) begin
                        min_r <= rdata;
                    end
                    idx <= idx + CNT_W'(1);
                end
                WRITE: begin
                    min_val <= min_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_min_scanner.sv
// tb_mem_min_scanner
//
// Self-checking bench for mem_min_scanner. A small word-addressed memory
// model answers the scanner's bus; directed scan records hold the operands
// and the hand-computed minimum, and each cycle of every scan is compared
// against the cycle-exact bus pattern. Hand-written sequences cover
// back-to-back scans and reset in the middle of a scan.
module tb_mem_min_scanner;

    localparam logic [31:0] SENTINEL = 32'h5A5A_A5A5;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_adr;
    logic [15:0] count;
    logic [31:0] dst_adr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        mrd;
    logic        mwr;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic [31:0] min_val;

    logic [31:0] mem [1024];
    logic        loadEn;
    logic [9:0]  loadIdx;
    logic [31:0] loadData;

    int compared;
    int failed;

    typedef struct {
        logic [31:0] base;
        logic [15:0] count;
        logic [31:0] dst;
        int          firstWord;
        logic [31:0] expMin;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] wordPool [22];

    mem_min_scanner #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_adr (base_adr),
        .count    (count),
        .dst_adr  (dst_adr),
        .adr      (adr),
        .wdata    (wdata),
        .mrd      (mrd),
        .mwr      (mwr),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .min_val  (min_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle memory: combinational read, write at the clock edge. The
    // bench preloads words through its own port while the scanner is idle.
    always @(posedge clk) begin
        if (mwr) begin
            mem[adr[11:2]] <= wdata;
        end else if (loadEn) begin
            mem[loadIdx] <= loadData;
        end
    end

    assign rdata = mem[adr[11:2]];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic loadWord(input logic [31:0] a, input logic [31:0] d);
        loadEn   = 1'b1;
        loadIdx  = a[11:2];
        loadData = d;
        @(posedge clk);
        #1;
        loadEn = 1'b0;
    endtask

    task automatic loadVec(input int k);
        for (int j = 0; j < int'(vecs[k].count); j++) begin
            loadWord(vecs[k].base + 32'(4 * j), wordPool[vecs[k].firstWord + j]);
        end
        loadWord(vecs[k].dst, SENTINEL);
    endtask

    // Runs one scan from acceptance to the done cycle, checking every cycle.
    // With fromDone set, start is raised during the previous scan's DONE
    // cycle and must only be taken after one idle cycle.
    task automatic applyStimulus(input int k, input bit fromDone);
        vec_t        v;
        int          n;
        int          last;
        logic        expMrd;
        logic        expMwr;
        logic        expDone;
        logic [31:0] expAdr;
        logic [31:0] actAdr;
        logic [31:0] expW;
        logic [31:0] actW;
        logic [67:0] expBus;
        logic [67:0] actBus;
        v = vecs[k];
        n = int'(v.count);
        last = (n == 0) ? 1 : n + 2;
        if (!fromDone) begin
            @(negedge clk);
            checkOutput($sformatf("idle_v%0d", k), 128'({busy, mrd, mwr, done}), 128'(4'b0000));
        end
        base_adr = v.base;
        count    = v.count;
        dst_adr  = v.dst;
        start    = 1'b1;
        if (fromDone) begin
            @(negedge clk);
            checkOutput($sformatf("idleGap_v%0d", k), 128'({busy, mrd, mwr, done}), 128'(4'b0000));
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        base_adr = 32'h0BAD_0000;
        count    = 16'd7;
        dst_adr  = 32'h0BAD_0004;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            expMrd  = (n != 0) && (c <= n);
            expMwr  = (n != 0) && (c == n + 1);
            expDone = (c == last);
            expAdr  = expMrd ? v.base + 32'(4 * (c - 1)) : (expMwr ? v.dst : 32'd0);
            actAdr  = (expMrd || expMwr) ? adr : 32'd0;
            expW    = expMwr ? v.expMin : 32'd0;
            actW    = expMwr ? wdata : 32'd0;
            expBus  = {expAdr, expW, expMrd, expMwr, 1'b1, expDone};
            actBus  = {actAdr, actW, mrd, mwr, busy, done};
            checkOutput($sformatf("bus_v%0d_c%0d", k, c), 128'(actBus), 128'(expBus));
        end
        checkOutput($sformatf("minVal_v%0d", k), 128'(min_val), 128'(v.expMin));
        checkOutput($sformatf("memDst_v%0d", k), 128'(mem[v.dst[11:2]]),
                    128'((n == 0) ? SENTINEL : v.expMin));
    endtask

    initial begin
        compared = 0;
        failed   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        base_adr = 32'd0;
        count    = 16'd0;
        dst_adr  = 32'd0;
        loadEn   = 1'b0;
        loadIdx  = 10'd0;
        loadData = 32'd0;

        wordPool = '{32'sd5, -32'sd3, 32'sd12, -32'sd3, 32'sd7, 32'sd0, 32'sd9, 32'sd100, -32'sd1, 32'sd4,
                     32'h8000_0000,
                     32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                     32'sd10, -32'sd5,
                     32'sd3, -32'sd8, 32'sd2,
                     -32'sd1, -32'sd2};
        vecs[0] = '{32'd1000,      16'd10, 32'd2000, 0,  32'hFFFF_FFFD};
        vecs[1] = '{32'd1100,      16'd1,  32'd2004, 10, 32'h8000_0000};
        vecs[2] = '{32'd1200,      16'd0,  32'd2008, 0,  32'h7FFF_FFFF};
        vecs[3] = '{32'd1300,      16'd4,  32'd2012, 11, 32'h7FFF_FFFF};
        vecs[4] = '{32'hFFFF_FFFC, 16'd2,  32'd2016, 15, 32'hFFFF_FFFB};
        vecs[5] = '{32'd1400,      16'd3,  32'd2020, 17, 32'hFFFF_FFF8};
        vecs[6] = '{32'd1500,      16'd2,  32'd2024, 20, 32'hFFFF_FFFE};

        #3;
        checkOutput("resetState", 128'({adr, wdata, mrd, mwr, busy, done, min_val}), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            loadVec(k);
            applyStimulus(k, 1'b0);
        end

        $display("[TB] back-to-back scans");
        loadVec(5);
        loadVec(6);
        applyStimulus(5, 1'b0);
        applyStimulus(6, 1'b1);

        $display("[TB] reset during READ with an ignored second start");
        loadVec(0);
        loadWord(32'd3000, SENTINEL);
        @(negedge clk);
        base_adr = 32'd1000;
        count    = 16'd10;
        dst_adr  = 32'd3000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3) begin
                base_adr = 32'd1200;
                count    = 16'd0;
                dst_adr  = 32'd2008;
                start    = 1'b1;
            end
            if (c == 4) begin
                start = 1'b0;
                checkOutput("ignoredStart", 128'({adr, mrd, busy, done}), 128'({32'd1012, 1'b1, 1'b1, 1'b0}));
            end
        end
        checkOutput("preResetAdr", 128'({adr, mrd}), 128'({32'd1016, 1'b1}));
        rst = 1'b1;
        #1;
        checkOutput("resetMidRead", 128'({adr, wdata, mrd, mwr, busy, done, min_val}), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
        end
        #1;
        checkOutput("noWriteAfterReset", 128'({mem[750], busy}), 128'({SENTINEL, 1'b0}));

        $display("[TB] reset pulse inside WRITE");
        loadVec(1);
        @(negedge clk);
        base_adr = vecs[1].base;
        count    = vecs[1].count;
        dst_adr  = vecs[1].dst;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("writeCycle", 128'({mwr, adr}), 128'({1'b1, 32'd2004}));
        rst = 1'b1;
        #1;
        checkOutput("writeKilled", 128'({adr, wdata, mrd, mwr, busy}), 128'(0));
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("memUnchanged", 128'({mem[501], busy}), 128'({SENTINEL, 1'b0}));

        $display("[TB] recovery scan after reset");
        loadVec(0);
        applyStimulus(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
